strm_pix_fifo: RTL and testbench
================================

Name: strm_pix_fifo

Overview:
- Synchronous first-word-fall-through buffer for the 8-bit pixel stream, with the end-of-line flag carried alongside each pixel.
- Sits directly upstream of the stream processing stage, which consumes its axis_s_* outputs.
- Absorbs source burstiness and back-pressure so the processing stage sees a steady valid stream.
- Optional packet mode holds output until a whole line is buffered.

Parameters:
DATA_W, 8, pixel width in bits.
DEPTH, 16, number of entries; power of two, >= 2.
CNT_W, $clog2(DEPTH)+1, width of the fill-level output; derived, do not override.

Ports:
clk  input  1  clock, all logic on rising edge.
rst  input  1  asynchronous active-high reset.
axis_m_data  input  DATA_W  upstream pixel.
axis_m_valid  input  1  upstream beat valid.
axis_m_ready  output  1  FIFO can accept a beat.
axis_m_last  input  1  upstream end-of-line.
axis_s_data  output  DATA_W  pixel to downstream stage.
axis_s_valid  output  1  output beat valid.
axis_s_ready  input  1  downstream accepts.
axis_s_last  output  1  end-of-line of the output beat.
level  output  CNT_W  entries currently stored, 0..DEPTH.

Behaviour:
- One clock; reset is asynchronous and active-high.
  - Asserting rst immediately clears the read pointer, write pointer and level to 0.
  - While rst is high, or after reset, the outputs are: axis_s_valid=0, axis_s_data=0, axis_s_last=0, axis_m_ready=0.
  - Reset mid-stream discards all stored beats with no flush.
- axis_m_ready is 1 from the first clock edge after rst deasserts whenever level < DEPTH.
  - It is registered or derived only from level.
  - There is no combinational path from axis_s_ready to axis_m_ready.
- Push: axis_m_valid & axis_m_ready at a rising edge stores {last, data} at wptr; wptr increments modulo DEPTH.
- Pop: axis_s_valid & axis_s_ready at a rising edge retires the head entry; rptr increments modulo DEPTH.
- Output is first-word-fall-through: axis_s_data and axis_s_last always reflect the head entry while axis_s_valid=1.
- Latency: a beat pushed into an empty FIFO at edge N shows axis_s_valid=1 after edge N. There is no same-cycle bypass.
- level arithmetic:
  - +1 on push only; -1 on pop only.
  - Unchanged on simultaneous push and pop.
  - Never exceeds DEPTH and never underflows.
- Full (level=DEPTH): axis_m_ready=0, so no push occurs even if a pop happens in the same cycle. ready returns to 1 on the cycle after the pop.
- Empty (level=0): axis_s_valid=0. axis_s_data and axis_s_last hold their last value; the downstream stage must ignore them.
- Ordering is strict FIFO. axis_s_last is delivered exactly with the pixel it was stored with.
- AXI-stream rules:
  - Once axis_s_valid=1 it stays 1, and axis_s_data and axis_s_last stay stable, until a pop.
  - Input beats presented while axis_m_ready=0 are ignored, not stored.
- Pointers are CNT_W-1 bits wide and wrap naturally. Full and empty are decided from level, not from pointer compare.

Optional Feature:
- Macro STRM_PIX_FIFO_PKT_MODE_EN.
- Defined: an internal line counter lines (CNT_W bits, reset 0) is maintained.
  - +1 on a push with axis_m_last=1.
  - -1 on a pop with axis_s_last=1.
  - Unchanged when both happen in the same cycle.
  - axis_s_valid = (level>0) & ((lines>0) | (level==DEPTH)). The full override prevents deadlock on lines longer than DEPTH.
  - Once asserted, axis_s_valid still obeys the hold-until-pop rule.
- Undefined: no line counter; axis_s_valid = (level>0).

Test Plan:
- Reset with rst high during clock running, then deassert -> all outputs 0 during reset; axis_m_ready=1 on the first edge after deassert; level=0.
- Push 0x11,0x22,0x33 (last on 0x33) with axis_s_ready=0 -> level=3; axis_s_data=0x11 held stable. Then set axis_s_ready=1 -> outputs 0x11,0x22,0x33 on consecutive cycles, last only on 0x33; level=0.
- Push 16 beats 0x00..0x0F with axis_s_ready=0 -> axis_m_ready=0 at level=16; a 17th beat is not stored. Pop once -> axis_m_ready=1 the next cycle.
- Continuous push and pop at level=5 for 40 cycles with random data -> level stays 5; output sequence equals input sequence; pointers wrap at least twice.
- Assert rst at level=7 mid-line -> axis_s_valid drops to 0 immediately (asynchronously); after release, level=0 and no stale beat emerges.
- With STRM_PIX_FIFO_PKT_MODE_EN defined:
  - Push 4 beats without last -> axis_s_valid stays 0.
  - Push a 5th beat with last -> valid rises after that edge and all 5 beats drain in order.
  - A 16-beat line with no last -> valid rises at level=16.

Source files
------------

// File: rtl/strm_pix_fifo_if.sv
// Pixel stream bus around the FIFO: upstream (axis_m_*), downstream (axis_s_*) and fill level.
// The slave modport is the FIFO side; master is the side driving pixels in and draining them.
interface strm_pix_fifo_if #(
  parameter int DATA_W = 8,
  parameter int CNT_W  = 5
);
  logic [DATA_W-1:0] axis_m_data;
  logic              axis_m_valid;
  logic              axis_m_ready;
  logic              axis_m_last;
  logic [DATA_W-1:0] axis_s_data;
  logic              axis_s_valid;
  logic              axis_s_ready;
  logic              axis_s_last;
  logic [CNT_W-1:0]  level;

  modport slave (
    input  axis_m_data, axis_m_valid, axis_m_last, axis_s_ready,
    output axis_m_ready, axis_s_data, axis_s_valid, axis_s_last, level
  );

  modport master (
    output axis_m_data, axis_m_valid, axis_m_last, axis_s_ready,
    input  axis_m_ready, axis_s_data, axis_s_valid, axis_s_last, level
  );
endinterface

// File: rtl/strm_pix_fifo.sv
// First-word-fall-through pixel FIFO carrying end-of-line with each pixel.
// Define STRM_PIX_FIFO_PKT_MODE_EN to hold output until a whole line (or a full buffer) is stored.
module strm_pix_fifo #(
  parameter  int DATA_W = 8,
  parameter  int DEPTH  = 16,
  localparam int CNT_W  = $clog2(DEPTH) + 1
) (
  input  logic               clk,
  input  logic               rst,
  strm_pix_fifo_if.slave     bus
);
  localparam int PTR_W = CNT_W - 1;
  localparam logic [CNT_W-1:0] C_FULL = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] C_ZERO = '0;
  localparam logic [CNT_W-1:0] C_ONE  = CNT_W'(1);

  logic [DATA_W:0]   r_mem [DEPTH];
  logic [PTR_W-1:0]  r_wptr;
  logic [PTR_W-1:0]  r_rptr;
  logic [CNT_W-1:0]  r_level;
  logic              r_started;
  logic [DATA_W:0]   r_head;

  logic              w_m_ready;
  logic              w_s_valid;
  logic              w_push;
  logic              w_pop;
  logic [PTR_W-1:0]  w_rptr_inc;
  logic [CNT_W-1:0]  w_after_pop;
  logic [CNT_W-1:0]  w_level_next;

  // Ready depends only on level plus a flag that keeps it low until the first edge out of reset.
  assign w_m_ready  = r_started & (r_level < C_FULL);
  assign w_push     = bus.axis_m_valid & w_m_ready;
  assign w_pop      = w_s_valid & bus.axis_s_ready;
  assign w_rptr_inc = r_rptr + 1'b1;
  assign w_after_pop = w_pop ? (r_level - C_ONE) : r_level;
  assign w_level_next = w_push ? (w_after_pop + C_ONE) : w_after_pop;

`ifdef STRM_PIX_FIFO_PKT_MODE_EN
  logic [CNT_W-1:0]  r_lines;
  logic              w_line_in;
  logic              w_line_out;

  assign w_line_in  = w_push & bus.axis_m_last;
  assign w_line_out = w_pop & r_head[DATA_W];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_lines <= '0;
    end else if (w_line_in & ~w_line_out) begin
      r_lines <= r_lines + C_ONE;
    end else if (w_line_out & ~w_line_in) begin
      r_lines <= r_lines - C_ONE;
    end
  end

  // Full override keeps lines longer than the buffer from deadlocking.
  assign w_s_valid = (r_level != C_ZERO) & ((r_lines != C_ZERO) | (r_level == C_FULL));
`else
  assign w_s_valid = (r_level != C_ZERO);
`endif

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wptr] <= {bus.axis_m_last, bus.axis_m_data};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wptr    <= '0;
      r_rptr    <= '0;
      r_level   <= '0;
      r_started <= 1'b0;
    end else begin
      r_started <= 1'b1;
      r_level   <= w_level_next;
      if (w_push) begin
        r_wptr <= r_wptr + 1'b1;
      end
      if (w_pop) begin
        r_rptr <= w_rptr_inc;
      end
    end
  end

  // Head register: loads the incoming beat when it lands in an otherwise empty buffer,
  // otherwise the next stored entry on a pop; holds in every other case.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_head <= '0;
    end else if (w_push && (w_after_pop == C_ZERO)) begin
      r_head <= {bus.axis_m_last, bus.axis_m_data};
    end else if (w_pop && (r_level > C_ONE)) begin
      r_head <= r_mem[w_rptr_inc];
    end
  end

  assign bus.axis_m_ready = w_m_ready;
  assign bus.axis_s_valid = w_s_valid;
  assign bus.axis_s_data  = r_head[DATA_W-1:0];
  assign bus.axis_s_last  = r_head[DATA_W];
  assign bus.level        = r_level;

endmodule

// File: tb/tb_strm_pix_fifo.sv
// Directed bench for strm_pix_fifo; packet-mode steps run when STRM_PIX_FIFO_PKT_MODE_EN is defined.
module tb_strm_pix_fifo;
  localparam int DATA_W = 8;
  localparam int DEPTH  = 16;
  localparam int CNT_W  = $clog2(DEPTH) + 1;
`ifdef STRM_PIX_FIFO_PKT_MODE_EN
  localparam bit PKT = 1'b1;
`else
  localparam bit PKT = 1'b0;
`endif

  logic clk;
  logic rst;
  int   n_total;
  int   n_pass;
  logic [7:0] q[$];
  logic [7:0] d;

  strm_pix_fifo_if #(.DATA_W(DATA_W), .CNT_W(CNT_W)) bus ();

  strm_pix_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_total = 0;
    n_pass  = 0;
    rst = 1'b1;
    bus.axis_m_data  = '0;
    bus.axis_m_valid = 1'b0;
    bus.axis_m_last  = 1'b0;
    bus.axis_s_ready = 1'b0;

    // Reset while clock runs
    repeat (3) tick();
    chk("rst_s_valid", 32'(bus.axis_s_valid), 32'd0);
    chk("rst_s_data",  32'(bus.axis_s_data),  32'd0);
    chk("rst_s_last",  32'(bus.axis_s_last),  32'd0);
    chk("rst_m_ready", 32'(bus.axis_m_ready), 32'd0);
    chk("rst_level",   32'(bus.level),        32'd0);
    rst = 1'b0;
    #1;
    chk("rel_m_ready_pre", 32'(bus.axis_m_ready), 32'd0);
    tick();
    chk("rel_m_ready", 32'(bus.axis_m_ready), 32'd1);
    chk("rel_level",   32'(bus.level),        32'd0);

    // Three beats in with downstream stalled
    bus.axis_m_valid = 1'b1;
    bus.axis_m_data = 8'h11; bus.axis_m_last = 1'b0; tick();
    chk("p3_valid_first", 32'(bus.axis_s_valid), PKT ? 32'd0 : 32'd1);
    bus.axis_m_data = 8'h22; tick();
    bus.axis_m_data = 8'h33; bus.axis_m_last = 1'b1; tick();
    bus.axis_m_valid = 1'b0; bus.axis_m_last = 1'b0;
    chk("p3_level", 32'(bus.level), 32'd3);
    chk("p3_head",  32'(bus.axis_s_data), 32'h11);
    tick();
    chk("p3_hold", 32'(bus.axis_s_data), 32'h11);
    chk("p3_valid", 32'(bus.axis_s_valid), 32'd1);
    bus.axis_s_ready = 1'b1;
    chk("d3_data0", 32'(bus.axis_s_data), 32'h11); chk("d3_last0", 32'(bus.axis_s_last), 32'd0); tick();
    chk("d3_data1", 32'(bus.axis_s_data), 32'h22); chk("d3_last1", 32'(bus.axis_s_last), 32'd0); tick();
    chk("d3_data2", 32'(bus.axis_s_data), 32'h33); chk("d3_last2", 32'(bus.axis_s_last), 32'd1); tick();
    bus.axis_s_ready = 1'b0;
    chk("d3_level", 32'(bus.level), 32'd0);
    chk("d3_valid", 32'(bus.axis_s_valid), 32'd0);

    // Fill to full, overflow attempt, single pop
    bus.axis_m_valid = 1'b1;
    for (int i = 0; i < 16; i++) begin
      bus.axis_m_data = 8'(i);
      bus.axis_m_last = (i == 15);
      tick();
    end
    chk("full_level",   32'(bus.level),        32'd16);
    chk("full_m_ready", 32'(bus.axis_m_ready), 32'd0);
    chk("full_valid",   32'(bus.axis_s_valid), 32'd1);
    bus.axis_m_data = 8'hAA; bus.axis_m_last = 1'b0;
    tick();
    chk("ovf_level", 32'(bus.level), 32'd16);
    bus.axis_m_valid = 1'b0;
    bus.axis_s_ready = 1'b1;
    chk("full_head", 32'(bus.axis_s_data), 32'h00);
    tick();
    bus.axis_s_ready = 1'b0;
    chk("pop1_m_ready", 32'(bus.axis_m_ready), 32'd1);
    chk("pop1_level",   32'(bus.level),        32'd15);
    bus.axis_s_ready = 1'b1;
    for (int i = 1; i < 16; i++) begin
      chk($sformatf("full_drain%0d", i), 32'(bus.axis_s_data), 32'(i));
      tick();
    end
    bus.axis_s_ready = 1'b0;
    chk("full_drain_level", 32'(bus.level), 32'd0);
    chk("full_drain_valid", 32'(bus.axis_s_valid), 32'd0);

    // Steady streaming at level 5
    bus.axis_m_valid = 1'b1;
    bus.axis_m_last  = 1'b1;
    for (int i = 0; i < 5; i++) begin
      d = 8'($urandom);
      bus.axis_m_data = d;
      q.push_back(d);
      tick();
    end
    bus.axis_s_ready = 1'b1;
    for (int i = 0; i < 40; i++) begin
      d = 8'($urandom);
      bus.axis_m_data = d;
      chk($sformatf("stream_data%0d", i), 32'(bus.axis_s_data), 32'(q[0]));
      tick();
      void'(q.pop_front());
      q.push_back(d);
      chk($sformatf("stream_level%0d", i), 32'(bus.level), 32'd5);
    end
    bus.axis_m_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("stream_tail%0d", i), 32'(bus.axis_s_data), 32'(q.pop_front()));
      tick();
    end
    bus.axis_s_ready = 1'b0;
    bus.axis_m_last  = 1'b0;
    chk("stream_level_end", 32'(bus.level), 32'd0);

    // Asynchronous reset mid-line
    bus.axis_m_valid = 1'b1;
    for (int i = 0; i < 7; i++) begin
      bus.axis_m_data = 8'(8'h40 + i);
      tick();
    end
    bus.axis_m_valid = 1'b0;
    chk("mid_level", 32'(bus.level), 32'd7);
    chk("mid_valid", 32'(bus.axis_s_valid), PKT ? 32'd0 : 32'd1);
    @(posedge clk);
    #3 rst = 1'b1;
    #1;
    chk("arst_valid",   32'(bus.axis_s_valid), 32'd0);
    chk("arst_level",   32'(bus.level),        32'd0);
    chk("arst_m_ready", 32'(bus.axis_m_ready), 32'd0);
    tick();
    tick();
    rst = 1'b0;
    tick();
    chk("post_m_ready", 32'(bus.axis_m_ready), 32'd1);
    chk("post_level",   32'(bus.level),        32'd0);
    chk("post_valid",   32'(bus.axis_s_valid), 32'd0);
    bus.axis_m_valid = 1'b1; bus.axis_m_data = 8'h5A; bus.axis_m_last = 1'b1;
    tick();
    bus.axis_m_valid = 1'b0; bus.axis_m_last = 1'b0;
    chk("post_push_valid", 32'(bus.axis_s_valid), 32'd1);
    chk("post_push_data",  32'(bus.axis_s_data),  32'h5A);
    chk("post_push_last",  32'(bus.axis_s_last),  32'd1);
    chk("post_push_level", 32'(bus.level),        32'd1);
    bus.axis_s_ready = 1'b1;
    tick();
    bus.axis_s_ready = 1'b0;
    chk("post_pop_level", 32'(bus.level), 32'd0);

`ifdef STRM_PIX_FIFO_PKT_MODE_EN
    // Output withheld until end-of-line arrives
    bus.axis_m_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      bus.axis_m_data = 8'(8'hA0 + i);
      bus.axis_m_last = 1'b0;
      tick();
      chk($sformatf("pkt_hold%0d", i), 32'(bus.axis_s_valid), 32'd0);
    end
    bus.axis_m_data = 8'hA4; bus.axis_m_last = 1'b1;
    tick();
    bus.axis_m_valid = 1'b0; bus.axis_m_last = 1'b0;
    chk("pkt_line_valid", 32'(bus.axis_s_valid), 32'd1);
    bus.axis_s_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("pkt_drain%0d", i), 32'(bus.axis_s_data), 32'(8'hA0 + i));
      chk($sformatf("pkt_last%0d", i),  32'(bus.axis_s_last), (i == 4) ? 32'd1 : 32'd0);
      tick();
    end
    bus.axis_s_ready = 1'b0;
    chk("pkt_empty_valid", 32'(bus.axis_s_valid), 32'd0);

    // Line longer than the buffer releases at full
    bus.axis_m_valid = 1'b1;
    for (int i = 0; i < 16; i++) begin
      bus.axis_m_data = 8'(8'hC0 + i);
      tick();
      if (i == 14) chk("pkt_long_l15", 32'(bus.axis_s_valid), 32'd0);
    end
    bus.axis_m_valid = 1'b0;
    chk("pkt_long_level", 32'(bus.level),        32'd16);
    chk("pkt_long_valid", 32'(bus.axis_s_valid), 32'd1);
    chk("pkt_long_head",  32'(bus.axis_s_data),  32'hC0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
